// File: rtl/dmtd_phase_meter_if.sv
// rtl/dmtd_phase_meter_if.sv - command, beat and result signals of the DMTD phase meter
//
// Groups everything except clk/rst.
//   master : drives start, n_meas, beat_a, beat_b, result_ready
//   slave  : drives busy, result_valid, phase_sum, period_last, n_done, timeout_err
`timescale 1ns/1ps
interface dmtd_phase_meter_if #(
   parameter int CNT_W  = 16,
   parameter int NAVG_W = 8,
   parameter int ACC_W  = 24
);
   logic              start;
   logic [NAVG_W-1:0] n_meas;
   logic              beat_a;
   logic              beat_b;
   logic              busy;
   logic              result_valid;
   logic              result_ready;
   logic [ACC_W-1:0]  phase_sum;
   logic [CNT_W-1:0]  period_last;
   logic [NAVG_W-1:0] n_done;
   logic              timeout_err;

   modport master (
      output start, n_meas, beat_a, beat_b, result_ready,
      input  busy, result_valid, phase_sum, period_last, n_done, timeout_err
   );

   modport slave (
      input  start, n_meas, beat_a, beat_b, result_ready,
      output busy, result_valid, phase_sum, period_last, n_done, timeout_err
   );
endinterface

// File: rtl/dmtd_phase_meter.sv
// rtl/dmtd_phase_meter.sv - DMTD measurement sequencer: deglitch, timestamp, accumulate A->B phase
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   bus (slave)  start/n_meas command, beat_a/beat_b inputs, result_valid/result_ready
//                handshake, phase_sum/period_last/n_done/timeout_err results, busy
`timescale 1ns/1ps
module dmtd_phase_meter #(
   parameter int CNT_W    = 16,
   parameter int NAVG_W   = 8,
   parameter int ACC_W    = 24,
   parameter int DEGLITCH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   dmtd_phase_meter_if.slave    bus
);

   localparam int DG_W = $clog2(DEGLITCH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_B,
      S_WAIT_A,
      S_DONE
   } state_t;

   // Channel index 0 = A (reference), 1 = B.
   logic [1:0]            beat;
   logic [1:0]            s_q, s_d;
   logic [1:0]            ev_q, ev_d;
   logic [1:0][DG_W-1:0]  run_q, run_d;
   logic                  ev_a, ev_b;

   logic [CNT_W-1:0]      tb_q, tb_d;
   logic [CNT_W-1:0]      wd_q, wd_d;
   logic [CNT_W-1:0]      ta_q, ta_d;
   logic [CNT_W-1:0]      per_q, per_d;
   logic [CNT_W-1:0]      diff;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [NAVG_W-1:0]     n_q, n_d;
   logic [NAVG_W-1:0]     nd_q, nd_d, nd_inc;
   logic                  to_q, to_d;
   logic                  init_q;
   logic                  wd_max;
   state_t                state_q, state_d;

   assign beat = {bus.beat_b, bus.beat_a};
   assign ev_a = ev_q[0];
   assign ev_b = ev_q[1];

   // The event register makes ev_x visible DEGLITCH cycles after the first
   // new-level sample, equally on both channels.
   always_comb begin
      s_d   = s_q;
      run_d = '0;
      ev_d  = '0;
      for (int ch = 0; ch < 2; ch++) begin
         if (beat[ch] != s_q[ch]) begin
            if (run_q[ch] == DG_W'(DEGLITCH - 1)) begin
               s_d[ch]  = ~s_q[ch];
               ev_d[ch] = ~s_q[ch];
            end else begin
               run_d[ch] = run_q[ch] + DG_W'(1);
            end
         end
      end
   end

   assign tb_d   = tb_q + CNT_W'(1);
   // Phase sample (t_b - t_a) and period (t_a - previous t_a) share one
   // modular subtraction against the latched t_a.
   assign diff   = tb_q - ta_q;
   assign nd_inc = nd_q + NAVG_W'(1);
   assign wd_max = &wd_q;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      ta_d    = ta_q;
      per_d   = per_q;
      acc_d   = acc_q;
      nd_d    = nd_q;
      to_d    = to_q;
      wd_d    = wd_q;

      case (state_q)
         S_IDLE: begin
            // init_q blocks a start coinciding with reset release.
            if (bus.start && init_q && (bus.n_meas != '0)) begin
               n_d     = bus.n_meas;
               acc_d   = '0;
               nd_d    = '0;
               to_d    = 1'b0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (wd_max) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else if (ev_a) begin
               ta_d    = tb_q;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (wd_max) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else if (ev_b) begin
               acc_d = acc_q + ACC_W'(diff);
               nd_d  = nd_inc;
               if (nd_inc == n_q) begin
                  state_d = S_DONE;
               end else if (ev_a) begin
                  // Coincident edges: sample used the old t_a, next A starts now.
                  ta_d  = tb_q;
                  per_d = diff;
               end else begin
                  state_d = S_WAIT_A;
               end
            end else if (ev_a) begin
               // Missed B edge: restart the pair from this A edge.
               ta_d  = tb_q;
               per_d = diff;
            end
         end
         S_WAIT_A: begin
            if (wd_max) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else if (ev_a) begin
               ta_d    = tb_q;
               per_d   = diff;
               state_d = S_WAIT_B;
            end
         end
         S_DONE: begin
            if (bus.result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_ARM) || (state_q == S_WAIT_A) || (state_q == S_WAIT_B)) begin
         wd_d = wd_q + CNT_W'(1);
      end
      if (state_d != state_q) begin
         wd_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q     <= '0;
         ev_q    <= '0;
         run_q   <= '0;
         tb_q    <= '0;
         wd_q    <= '0;
         ta_q    <= '0;
         per_q   <= '0;
         acc_q   <= '0;
         n_q     <= '0;
         nd_q    <= '0;
         to_q    <= 1'b0;
         init_q  <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         s_q     <= s_d;
         ev_q    <= ev_d;
         run_q   <= run_d;
         tb_q    <= tb_d;
         wd_q    <= wd_d;
         ta_q    <= ta_d;
         per_q   <= per_d;
         acc_q   <= acc_d;
         n_q     <= n_d;
         nd_q    <= nd_d;
         to_q    <= to_d;
         init_q  <= 1'b1;
         state_q <= state_d;
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.result_valid = (state_q == S_DONE);
   assign bus.phase_sum    = acc_q;
   assign bus.period_last  = per_q;
   assign bus.n_done       = nd_q;
   assign bus.timeout_err  = to_q;

endmodule

// File: tb/tb_dmtd_phase_meter.sv
// tb/tb_dmtd_phase_meter.sv - self-checking bench for dmtd_phase_meter
`timescale 1ns/1ps
module tb_dmtd_phase_meter;

   typedef struct {
      logic [31:0] ps;
      logic [31:0] per;
      logic [31:0] nd;
      logic        to;
   } exp_t;

   typedef struct {
      logic [31:0] ps;
      logic [31:0] per;
      logic [31:0] nd;
      logic        to;
      logic        valid;
      logic        busy;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   rel_cyc = 0;

   exp_t q16[$];
   exp_t q8[$];
   int   ea[$];
   int   eb[$];
   int   ga[$];
   int   gl[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmtd_phase_meter_if #(.CNT_W(16), .NAVG_W(8), .ACC_W(24)) if16 ();
   dmtd_phase_meter_if #(.CNT_W(8),  .NAVG_W(8), .ACC_W(16)) if8 ();

   dmtd_phase_meter #(.CNT_W(16), .NAVG_W(8), .ACC_W(24), .DEGLITCH(4)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (if16)
   );

   dmtd_phase_meter #(.CNT_W(8), .NAVG_W(8), .ACC_W(16), .DEGLITCH(4)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int sel, input logic st, input logic [7:0] nm,
                         input logic a, input logic b, input logic rdy);
      if (sel == 0) begin
         if16.start = st; if16.n_meas = nm; if16.beat_a = a; if16.beat_b = b; if16.result_ready = rdy;
      end else begin
         if8.start = st; if8.n_meas = nm; if8.beat_a = a; if8.beat_b = b; if8.result_ready = rdy;
      end
   endtask

   function automatic obs_t observe(input int sel);
      obs_t o;
      if (sel == 0) begin
         o.ps = 32'(if16.phase_sum); o.per = 32'(if16.period_last); o.nd = 32'(if16.n_done);
         o.to = if16.timeout_err; o.valid = if16.result_valid; o.busy = if16.busy;
      end else begin
         o.ps = 32'(if8.phase_sum); o.per = 32'(if8.period_last); o.nd = 32'(if8.n_done);
         o.to = if8.timeout_err; o.valid = if8.result_valid; o.busy = if8.busy;
      end
      return o;
   endfunction

   task automatic start_run(input int sel, input logic [7:0] n, input exp_t e, input string tag);
      obs_t o;
      set_in(sel, 1'b1, n, 1'b0, 1'b0, 1'b0);
      step();
      set_in(sel, 1'b0, n, 1'b0, 1'b0, 1'b0);
      if (sel == 0) q16.push_back(e); else q8.push_back(e);
      o = observe(sel);
      chk({tag, "_busy_rise"}, 32'(o.busy), 32'd1);
   endtask

   // Drives beat waveforms from the edge lists ea/eb (high for 'width'
   // cycles) plus glitch pulses ga/gl on A; reports the cycle result_valid
   // was first seen and the cycle of local index 0.
   task automatic gen(input int sel, input int width, input int total,
                      output int c0, output int vcyc);
      obs_t o;
      logic a, b;
      vcyc = -1;
      c0   = 0;
      for (int i = 0; i < total; i++) begin
         step();
         if (i == 0) c0 = cyc;
         o = observe(sel);
         if (o.valid && vcyc < 0) vcyc = cyc;
         a = 1'b0;
         b = 1'b0;
         foreach (ea[k]) if (i >= ea[k] && i < ea[k] + width) a = 1'b1;
         foreach (ga[k]) if (i >= ga[k] && i < ga[k] + gl[k]) a = 1'b1;
         foreach (eb[k]) if (i >= eb[k] && i < eb[k] + width) b = 1'b1;
         set_in(sel, 1'b0, 8'd0, a, b, 1'b0);
      end
      set_in(sel, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_result(input int sel, input string tag);
      obs_t o;
      exp_t e;
      int   ok;
      ok = 0;
      for (int k = 0; k < 4000; k++) begin
         o = observe(sel);
         if (o.valid) begin
            ok = 1;
            break;
         end
         step();
      end
      chk({tag, "_valid"}, 32'(ok), 32'd1);
      e.ps = 'x; e.per = 'x; e.nd = 'x; e.to = 1'bx;
      if (sel == 0 && q16.size() > 0) e = q16.pop_front();
      else if (sel == 1 && q8.size() > 0) e = q8.pop_front();
      o = observe(sel);
      chk({tag, "_phase_sum"},   o.ps,  e.ps);
      chk({tag, "_period_last"}, o.per, e.per);
      chk({tag, "_n_done"},      o.nd,  e.nd);
      chk({tag, "_timeout_err"}, 32'(o.to), 32'(e.to));
   endtask

   task automatic ack(input int sel, input string tag);
      obs_t o;
      set_in(sel, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      step();
      set_in(sel, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      o = observe(sel);
      chk({tag, "_idle_busy"},  32'(o.busy),  32'd0);
      chk({tag, "_idle_valid"}, 32'(o.valid), 32'd0);
   endtask

   initial begin
      obs_t o;
      exp_t e;
      int   c0, vcyc, off;

      set_in(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      set_in(1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

      // Reset state.
      #2;
      o = observe(0);
      chk("rst_busy", 32'(o.busy), 32'd0);
      chk("rst_valid", 32'(o.valid), 32'd0);
      chk("rst_timeout", 32'(o.to), 32'd0);
      chk("rst_phase_sum", o.ps, 32'd0);
      chk("rst_period", o.per, 32'd0);
      chk("rst_n_done", o.nd, 32'd0);
      o = observe(1);
      chk("rst8_busy", 32'(o.busy), 32'd0);
      chk("rst8_phase_sum", o.ps, 32'd0);
      repeat (3) @(posedge clk);

      // Release mid-cycle with start already high: must be ignored.
      @(negedge clk);
      rst = 1'b0;
      rel_cyc = cyc;
      set_in(0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      step();
      set_in(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      o = observe(0);
      chk("start_at_release_ignored", 32'(o.busy), 32'd0);

      // start with n_meas = 0 is ignored.
      set_in(0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      step();
      set_in(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      o = observe(0);
      chk("start_n0_ignored", 32'(o.busy), 32'd0);

      // Nominal: period 1000, lag 250, four samples.
      e.ps = 32'd1000; e.per = 32'd1000; e.nd = 32'd4; e.to = 1'b0;
      start_run(0, 8'd4, e, "nom");
      ea = '{100, 1100, 2100, 3100};
      eb = '{350, 1350, 2350, 3350};
      ga = {};
      gl = {};
      gen(0, 500, 3360, c0, vcyc);
      chk("nom_valid_latency", 32'(vcyc), 32'(c0 + 3350 + 4 + 1));
      check_result(0, "nom");
      ack(0, "nom");

      // Same run with 2- and 3-cycle blips on A 40 cycles before each edge.
      start_run(0, 8'd4, e, "glitch");
      ga = '{60, 1060, 2060, 3060};
      gl = '{2, 3, 2, 3};
      gen(0, 500, 3360, c0, vcyc);
      chk("glitch_valid_latency", 32'(vcyc), 32'(c0 + 3350 + 4 + 1));
      check_result(0, "glitch");
      ga = {};
      gl = {};

      // Backpressure: result held, start ignored while result_ready is low.
      for (int k = 0; k < 10; k++) begin
         set_in(0, (k % 2) == 0, 8'd5, 1'b0, 1'b0, 1'b0);
         step();
         o = observe(0);
         chk("bp_valid", 32'(o.valid), 32'd1);
         chk("bp_phase_sum", o.ps, 32'd1000);
         chk("bp_n_done", o.nd, 32'd4);
      end
      ack(0, "bp");
      o = observe(0);
      chk("idle_hold_phase_sum", o.ps, 32'd1000);
      chk("idle_hold_period", o.per, 32'd1000);

      // Coincident A/B in WAIT_B: sample uses the old t_a, FSM stays in WAIT_B.
      e.ps = 32'd400; e.per = 32'd300; e.nd = 32'd2; e.to = 1'b0;
      start_run(0, 8'd2, e, "coin");
      ea = '{10, 310};
      eb = '{310, 410};
      gen(0, 50, 430, c0, vcyc);
      chk("coin_valid_latency", 32'(vcyc), 32'(c0 + 410 + 4 + 1));
      check_result(0, "coin");
      ack(0, "coin");

      // 8-bit timebase: A event lands on tb = 250, B 20 cycles later.
      e.ps = 32'd20; e.per = 32'd0; e.nd = 32'd1; e.to = 1'b0;
      start_run(1, 8'd1, e, "wrap");
      off = (((250 - 4 + rel_cyc - (cyc + 1)) % 256) + 256) % 256;
      if (off < 5) off += 256;
      ea = '{off};
      eb = '{off + 20};
      gen(1, 10, off + 30, c0, vcyc);
      check_result(1, "wrap");
      ack(1, "wrap");

      // Watchdog: B stops after one sample; A keeps running.
      e.ps = 32'd30; e.per = 32'd100; e.nd = 32'd1; e.to = 1'b1;
      start_run(1, 8'd3, e, "tout");
      ea = '{10, 110, 210, 310, 410, 510};
      eb = '{40};
      gen(1, 30, 600, c0, vcyc);
      chk("tout_valid_latency", 32'(vcyc), 32'(c0 + 114 + 1 + 255 + 1));
      check_result(1, "tout");
      ack(1, "tout");

      // Asynchronous reset in the middle of a run.
      set_in(0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
      step();
      set_in(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      ea = '{10};
      eb = '{60};
      gen(0, 20, 100, c0, vcyc);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      o = observe(0);
      chk("midrst_busy", 32'(o.busy), 32'd0);
      chk("midrst_valid", 32'(o.valid), 32'd0);
      chk("midrst_phase_sum", o.ps, 32'd0);
      chk("midrst_period", o.per, 32'd0);
      chk("midrst_n_done", o.nd, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
